// File: rtl/microcode_sequencer.sv
// Microcode sequencer with built-in control-store loader.
// After reset the EPROM is copied into control-store RAM, then the
// microprogram runs from address 0 with conditional jumps, a call/return
// stack, halt detection and stack-fault detection.
module microcode_sequencer #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    WORD_WIDTH  = 64,
    parameter int                    STACK_DEPTH = 4,
    parameter int                    NUM_COND    = 4,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR   = ADDR_WIDTH'((1 << ADDR_WIDTH) - 2),
    localparam int                   SEL_W       = $clog2(NUM_COND),
    localparam int                   LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            cmd,
    input  logic [SEL_W-1:0]      cond_sel,
    input  logic [NUM_COND-1:0]   cond,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    output logic                  cs_we,
    output logic [WORD_WIDTH-1:0] cs_wdata,
    output logic                  ready,
    output logic                  halted,
    output logic                  fault,
    output logic [LVL_W-1:0]      stack_level
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CMD_NEXT     = 3'd0,
        CMD_JUMP     = 3'd1,
        CMD_JUMP_IF  = 3'd2,
        CMD_JUMP_IFN = 3'd3,
        CMD_CALL     = 3'd4,
        CMD_RET      = 3'd5,
        CMD_HOLD     = 3'd6,
        CMD_NEXT_ALT = 3'd7
    } cmd_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_WIDTH-1:0]   cs_addr_q, cs_addr_d;   // doubles as upc outside LOAD
    logic                    cs_we_q, cs_we_d;
    logic [WORD_WIDTH-1:0]   cs_wdata_q, cs_wdata_d;
    logic                    ready_q, ready_d;
    logic                    halted_q, halted_d;
    logic                    fault_q, fault_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [ADDR_WIDTH-1:0]   stack_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0]   stack_d [STACK_DEPTH];

    logic                    flag;
    logic [ADDR_WIDTH-1:0]   upc_inc;
    logic [ADDR_WIDTH-1:0]   stack_top;
    logic                    stack_full;
    logic                    stack_empty;
    logic                    at_halt;
    logic                    load_done;
    logic                    push;
    logic                    pop;
    logic                    overflow;
    logic                    underflow;

    // State register: every flop loads its _d value, reset clears everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= ST_LOAD;
            rom_addr_q <= '0;
            cs_addr_q  <= '0;
            cs_we_q    <= 1'b0;
            cs_wdata_q <= '0;
            ready_q    <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            level_q    <= '0;
            // NOTE: the return stack is small flop storage, so it is cleared
            // on reset; a RAM-based store would be left uninitialised.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            cs_addr_q  <= cs_addr_d;
            cs_we_q    <= cs_we_d;
            cs_wdata_q <= cs_wdata_d;
            ready_q    <= ready_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            level_q    <= level_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    // Command decode: flag select, stack status and push/pop/fault requests.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        flag      = 1'b0;
        stack_top = '0;
        push      = 1'b0;
        pop       = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;

        // Selects beyond NUM_COND-1 never match and read as 0.
        for (int i = 0; i < NUM_COND; i++) begin
            if (int'(cond_sel) == i) flag = cond[i];
        end

        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (LVL_W'(i + 1) == level_q) stack_top = stack_q[i];
        end

        upc_inc     = cs_addr_q + ADDR_WIDTH'(1);
        stack_full  = (level_q == LVL_W'(STACK_DEPTH));
        stack_empty = (level_q == '0);
        at_halt     = (cs_addr_q == HALT_ADDR);
        load_done   = cs_we_q && (cs_addr_q == '1);

        if (state_q == ST_RUN && !at_halt) begin
            if (cmd_e'(cmd) == CMD_CALL) begin
                if (stack_full) overflow = 1'b1;
                else            push     = 1'b1;
            end else if (cmd_e'(cmd) == CMD_RET) begin
                if (stack_empty) underflow = 1'b1;
                else             pop       = 1'b1;
            end
        end
    end

    // Next-state logic: LOAD -> RUN -> HALT or FAULT, terminal until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (load_done) state_d = ST_RUN;
            ST_RUN: begin
                if (at_halt)                     state_d = ST_HALT;
                else if (overflow || underflow)  state_d = ST_FAULT;
            end
            default: state_d = state_q;
        endcase
    end

    // Output/datapath logic: loader copy, upc sequencing and stack updates.
    always_comb begin
        rom_addr_d = rom_addr_q;
        cs_addr_d  = cs_addr_q;
        cs_we_d    = 1'b0;
        cs_wdata_d = cs_wdata_q;
        level_d    = level_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_d[i] = stack_q[i];
        end

        case (state_q)
            ST_LOAD: begin
                if (load_done) begin
                    cs_addr_d  = '0;
                    rom_addr_d = '0;
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                    cs_addr_d  = rom_addr_q;
                    cs_wdata_d = rom_data;
                    cs_we_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!at_halt) begin
                    case (cmd_e'(cmd))
                        CMD_JUMP:     cs_addr_d = jump_addr;
                        CMD_JUMP_IF:  cs_addr_d = flag ? jump_addr : upc_inc;
                        CMD_JUMP_IFN: cs_addr_d = flag ? upc_inc : jump_addr;
                        CMD_CALL:     if (push) cs_addr_d = jump_addr;
                        CMD_RET:      if (pop) cs_addr_d = stack_top;
                        CMD_HOLD:     cs_addr_d = cs_addr_q;
                        default:      cs_addr_d = upc_inc;
                    endcase
                end
                if (push) begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (LVL_W'(i) == level_q) stack_d[i] = upc_inc;
                    end
                    level_d = level_q + LVL_W'(1);
                end else if (pop) begin
                    level_d = level_q - LVL_W'(1);
                end
            end
            default: ;
        endcase

        ready_d  = (state_d != ST_LOAD);
        halted_d = (state_d == ST_HALT);
        fault_d  = (state_d == ST_FAULT);
    end

    assign rom_addr    = rom_addr_q;
    assign cs_addr     = cs_addr_q;
    assign cs_we       = cs_we_q;
    assign cs_wdata    = cs_wdata_q;
    assign ready       = ready_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign stack_level = level_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer (ADDR_WIDTH=4, 16-bit words).
// The driver advances a queue-based reference model one edge at a time and
// pushes the expected outputs; a monitor pops and compares every cycle.
module tb_microcode_sequencer;

    localparam int AW = 4;
    localparam int WW = 16;
    localparam int SD = 4;
    localparam int NC = 4;
    localparam int NWORDS = 1 << AW;
    localparam int HALT = NWORDS - 2;

    logic          clk;
    logic          reset;
    logic [2:0]    cmd;
    logic [1:0]    cond_sel;
    logic [NC-1:0] cond;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] rom_addr;
    logic [WW-1:0] rom_data;
    logic [AW-1:0] cs_addr;
    logic          cs_we;
    logic [WW-1:0] cs_wdata;
    logic          ready;
    logic          halted;
    logic          fault;
    logic [2:0]    stack_level;

    microcode_sequencer #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .STACK_DEPTH(SD),
        .NUM_COND   (NC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cond_sel   (cond_sel),
        .cond       (cond),
        .jump_addr  (jump_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .cs_addr    (cs_addr),
        .cs_we      (cs_we),
        .cs_wdata   (cs_wdata),
        .ready      (ready),
        .halted     (halted),
        .fault      (fault),
        .stack_level(stack_level)
    );

    // Combinational EPROM: word i = i * 0x0101.
    assign rom_data = WW'(rom_addr) * 16'h0101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [WW-1:0] wdata;
        bit            chk_wdata;
        logic [AW-1:0] rom;
        bit            chk_rom;
        logic          ready;
        logic          halted;
        logic          fault;
        logic [2:0]    level;
    } exp_t;

    typedef enum {M_LOAD, M_RUN, M_HALT, M_FAULT} mmode_e;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     mon_en   = 1'b0;

    // Reference model state
    mmode_e m_mode  = M_LOAD;
    int     m_written;
    int     m_upc;
    int     m_stack[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    // Apply inputs for the next edge, predict its outcome, then advance.
    task automatic cycle(input bit rst, input int c, input int cs, input logic [3:0] cnd, input int ja);
        exp_t e;
        bit   f;
        reset     = rst;
        cmd       = 3'(c);
        cond_sel  = 2'(cs);
        cond      = cnd;
        jump_addr = AW'(ja);

        e = '{default: 0};
        if (rst) begin
            m_mode    = M_LOAD;
            m_written = 0;
            m_upc     = 0;
            m_stack.delete();
            e.chk_wdata = 1'b1;
            e.chk_rom   = 1'b1;
        end else begin
            case (m_mode)
                M_LOAD: begin
                    if (m_written < NWORDS) begin
                        e.we        = 1'b1;
                        e.addr      = AW'(m_written);
                        e.wdata     = WW'(m_written * 257);
                        e.chk_wdata = 1'b1;
                        m_written++;
                        e.rom       = AW'(m_written % NWORDS);
                        e.chk_rom   = 1'b1;
                    end else begin
                        m_mode = M_RUN;
                        m_upc  = 0;
                    end
                end
                M_RUN: begin
                    f = (cs < NC) ? cnd[cs] : 1'b0;
                    if (m_upc == HALT) begin
                        m_mode = M_HALT;
                    end else begin
                        case (c)
                            1: m_upc = ja;
                            2: m_upc = f ? ja : (m_upc + 1) % NWORDS;
                            3: m_upc = f ? (m_upc + 1) % NWORDS : ja;
                            4: begin
                                if (m_stack.size() == SD) m_mode = M_FAULT;
                                else begin
                                    m_stack.push_back((m_upc + 1) % NWORDS);
                                    m_upc = ja;
                                end
                            end
                            5: begin
                                if (m_stack.size() == 0) m_mode = M_FAULT;
                                else m_upc = m_stack.pop_back();
                            end
                            6: ;
                            default: m_upc = (m_upc + 1) % NWORDS;
                        endcase
                    end
                end
                default: ;
            endcase
            if (m_mode != M_LOAD) begin
                e.addr   = AW'(m_upc);
                e.ready  = 1'b1;
                e.halted = (m_mode == M_HALT);
                e.fault  = (m_mode == M_FAULT);
            end
            e.level = 3'(m_stack.size());
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle(input bit rst);
        cycle(rst, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endtask

    // Reset for one edge, then run the full load (16 writes + handover edge)
    // with garbage commands, which the loader must ignore.
    task automatic reload();
        rand_cycle(1'b1);
        for (int i = 0; i < NWORDS + 1; i++) rand_cycle(1'b0);
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underrun @%0t: got no expectation, expected one", $time);
            end else begin
                e = exp_q.pop_front();
                check("cs_addr", 64'(cs_addr), 64'(e.addr));
                check("cs_we", 64'(cs_we), 64'(e.we));
                if (e.chk_wdata) check("cs_wdata", 64'(cs_wdata), 64'(e.wdata));
                if (e.chk_rom)   check("rom_addr", 64'(rom_addr), 64'(e.rom));
                check("ready", 64'(ready), 64'(e.ready));
                check("halted", 64'(halted), 64'(e.halted));
                check("fault", 64'(fault), 64'(e.fault));
                check("stack_level", 64'(stack_level), 64'(e.level));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog @%0t: got no end of test, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, ja;
        reset = 1'b1; cmd = '0; cond_sel = '0; cond = '0; jump_addr = '0;
        cycle(1'b1, 0, 0, 4'h0, 0);
        mon_en = 1'b1;
        cycle(1'b1, 0, 0, 4'h0, 0);

        // Mid-load reset after word 7, then a complete reload from 0.
        for (int i = 0; i < 8; i++) rand_cycle(1'b0);
        rand_cycle(1'b1);
        for (int i = 0; i < NWORDS + 1; i++) rand_cycle(1'b0);

        // Branches
        cycle(1'b0, 1, 0, 4'b0000, 'hF);   // JUMP 0xF
        cycle(1'b0, 0, 0, 4'b0000, 0);     // NEXT wraps to 0
        cycle(1'b0, 1, 0, 4'b0000, 'h9);   // JUMP 0x9
        cycle(1'b0, 2, 2, 4'b0100, 'h3);   // JUMP_IF taken -> 3
        cycle(1'b0, 2, 1, 4'b0100, 'hC);   // JUMP_IF not taken -> 4
        cycle(1'b0, 3, 2, 4'b0100, 'hC);   // JUMP_IFN not taken -> 5
        cycle(1'b0, 3, 1, 4'b0100, 'h0);   // JUMP_IFN taken -> 0
        cycle(1'b0, 1, 0, 4'b0000, 'h2);   // JUMP 0x2
        // Nested calls and returns
        cycle(1'b0, 4, 0, 4'b0000, 'h8);
        cycle(1'b0, 4, 0, 4'b0000, 'hA);
        cycle(1'b0, 4, 0, 4'b0000, 'hC);
        cycle(1'b0, 5, 0, 4'b0000, 0);
        cycle(1'b0, 5, 0, 4'b0000, 0);
        cycle(1'b0, 5, 0, 4'b0000, 0);
        cycle(1'b0, 6, 0, 4'b0000, 'h7);   // HOLD
        cycle(1'b0, 7, 0, 4'b0000, 'h7);   // cmd 7 behaves as NEXT

        // Stack overflow: four calls fill the stack, the fifth faults.
        reload();
        for (int i = 0; i < SD + 1; i++) cycle(1'b0, 4, 0, 4'b0000, 2 * i + 1);
        for (int i = 0; i < 3; i++) rand_cycle(1'b0);

        // Stack underflow
        reload();
        cycle(1'b0, 5, 0, 4'b0000, 0);
        for (int i = 0; i < 3; i++) rand_cycle(1'b0);

        // Halt
        reload();
        cycle(1'b0, 1, 0, 4'b0000, HALT);
        for (int i = 0; i < 4; i++) rand_cycle(1'b0);

        // Randomised run, reloading whenever a terminal state is reached.
        reload();
        for (int n = 0; n < 600; n++) begin
            if (m_mode == M_HALT || m_mode == M_FAULT) begin
                rand_cycle(1'b0);
                reload();
            end else begin
                c  = int'($urandom_range(0, 7));
                ja = int'($urandom_range(0, 15));
                if (ja == HALT && $urandom_range(0, 3) != 0) ja = 0;
                cycle(1'b0, c, int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), ja);
            end
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
